// File: rtl/motor_drive.sv
// Two-wheel differential motor driver: decodes the navigation mode into per-wheel
// direction/duty targets, ramps duty, inserts coast time on reversal, and generates PWM.
module motor_drive #(
  parameter int PWM_BITS    = 10,
  parameter int DUTY_FAST   = 700,
  parameter int DUTY_TURN   = 600,
  parameter int DUTY_SLOW   = 450,
  parameter int RAMP_DIV    = 50000,
  parameter int RAMP_STEP   = 32,
  parameter int DEAD_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] mode,
  output logic [1:0] pwm,
  output logic [1:0] l_IN,
  output logic [1:0] r_IN,
  output logic       settled
);

  localparam int W1       = PWM_BITS + 1;
  localparam int MAX_DUTY = (1 << PWM_BITS) - 1;
  localparam int STEP_MAX = (1 << W1) - 1;
  localparam int RW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW       = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [W1-1:0]       STEP_C    = W1'((RAMP_STEP > STEP_MAX) ? STEP_MAX : RAMP_STEP);
  localparam logic [PWM_BITS-1:0] FAST_C    = PWM_BITS'((DUTY_FAST > MAX_DUTY) ? MAX_DUTY : DUTY_FAST);
  localparam logic [PWM_BITS-1:0] TURN_C    = PWM_BITS'((DUTY_TURN > MAX_DUTY) ? MAX_DUTY : DUTY_TURN);
  localparam logic [PWM_BITS-1:0] SLOW_C    = PWM_BITS'((DUTY_SLOW > MAX_DUTY) ? MAX_DUTY : DUTY_SLOW);

  typedef enum logic [1:0] {
    DIR_OFF = 2'b00,
    DIR_REV = 2'b01,
    DIR_FWD = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DECEL,
    ST_DEAD
  } wheel_e;

  // Wheel index 1 is the left wheel, index 0 the right wheel, matching pwm bit order.
  wheel_e                   state_q [2];
  wheel_e                   state_d [2];
  dir_e                     dir_q   [2];
  dir_e                     dir_d   [2];
  dir_e                     tgtDir  [2];
  logic [1:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0][PWM_BITS-1:0] cmp_q, cmp_d;
  logic [1:0][PWM_BITS-1:0] tgtDuty;
  logic [1:0][DW-1:0]       deadCnt_q, deadCnt_d;
  logic [PWM_BITS-1:0]      pwmCnt_q, pwmCnt_d;
  logic [RW-1:0]            rampCnt_q, rampCnt_d;
  logic                     rampTick;
  logic                     pwmWrap;
  logic                     errorMode;

  function automatic logic [PWM_BITS-1:0] rampToward(input logic [PWM_BITS-1:0] cur,
                                                     input logic [PWM_BITS-1:0] tgt);
    logic [W1-1:0] curW;
    logic [W1-1:0] tgtW;
    curW = {1'b0, cur};
    tgtW = {1'b0, tgt};
    if (curW < tgtW) begin
      if ((tgtW - curW) <= STEP_C) rampToward = tgt;
      else                         rampToward = PWM_BITS'(curW + STEP_C);
    end else begin
      if ((curW - tgtW) <= STEP_C) rampToward = tgt;
      else                         rampToward = PWM_BITS'(curW - STEP_C);
    end
  endfunction

  assign errorMode = (mode == 5'd31);
  assign rampTick  = (rampCnt_q == RAMP_LAST);
  assign pwmWrap   = (pwmCnt_q == '1);
  assign rampCnt_d = rampTick ? '0 : rampCnt_q + 1'b1;
  assign pwmCnt_d  = pwmCnt_q + 1'b1;

  always_comb begin
    tgtDir[1]  = DIR_OFF;
    tgtDir[0]  = DIR_OFF;
    tgtDuty    = '0;
    case (mode)
      5'd3, 5'd4: begin
        tgtDir[1] = DIR_FWD;  tgtDuty[1] = FAST_C;
        tgtDir[0] = DIR_FWD;  tgtDuty[0] = FAST_C;
      end
      5'd5: begin
        tgtDir[1] = DIR_REV;  tgtDuty[1] = TURN_C;
        tgtDir[0] = DIR_FWD;  tgtDuty[0] = TURN_C;
      end
      5'd6: begin
        tgtDir[1] = DIR_FWD;  tgtDuty[1] = TURN_C;
        tgtDir[0] = DIR_REV;  tgtDuty[0] = TURN_C;
      end
      5'd7: begin
        tgtDir[1] = DIR_REV;  tgtDuty[1] = SLOW_C;
        tgtDir[0] = DIR_REV;  tgtDuty[0] = SLOW_C;
      end
      5'd8: begin
        tgtDir[0] = DIR_REV;  tgtDuty[0] = SLOW_C;
      end
      default: ;
    endcase
  end

  // A reversal must ramp to zero and coast before the new direction is applied;
  // stopping (target OFF) just ramps down in RUN and drops IN once duty is zero.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      state_d[w]   = state_q[w];
      dir_d[w]     = dir_q[w];
      duty_d[w]    = duty_q[w];
      deadCnt_d[w] = deadCnt_q[w];
      case (state_q[w])
        ST_RUN: begin
          if (dir_q[w] != DIR_OFF && tgtDir[w] != DIR_OFF && tgtDir[w] != dir_q[w]) begin
            state_d[w] = ST_DECEL;
          end else begin
            if (rampTick) duty_d[w] = rampToward(duty_q[w], tgtDuty[w]);
            if (tgtDir[w] != DIR_OFF)   dir_d[w] = tgtDir[w];
            else if (duty_d[w] == '0)   dir_d[w] = DIR_OFF;
          end
        end
        ST_DECEL: begin
          if (tgtDir[w] == dir_q[w]) begin
            state_d[w] = ST_RUN;
          end else begin
            if (rampTick) duty_d[w] = rampToward(duty_q[w], '0);
            if (duty_d[w] == '0) begin
              state_d[w]   = ST_DEAD;
              deadCnt_d[w] = '0;
            end
          end
        end
        ST_DEAD: begin
          duty_d[w] = '0;
          if (deadCnt_q[w] == DEAD_LAST) begin
            state_d[w]   = ST_RUN;
            dir_d[w]     = tgtDir[w];
            deadCnt_d[w] = '0;
          end else begin
            deadCnt_d[w] = deadCnt_q[w] + 1'b1;
          end
        end
        default: state_d[w] = ST_RUN;
      endcase

      if (errorMode) begin
        state_d[w]   = ST_RUN;
        dir_d[w]     = DIR_OFF;
        duty_d[w]    = '0;
        deadCnt_d[w] = '0;
      end

      if (errorMode)    cmp_d[w] = '0;
      else if (pwmWrap) cmp_d[w] = duty_q[w];
      else              cmp_d[w] = cmp_q[w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwmCnt_q  <= '0;
      rampCnt_q <= '0;
      duty_q    <= '0;
      cmp_q     <= '0;
      deadCnt_q <= '0;
      for (int w = 0; w < 2; w++) begin
        state_q[w] <= ST_RUN;
        dir_q[w]   <= DIR_OFF;
      end
    end else begin
      pwmCnt_q  <= pwmCnt_d;
      rampCnt_q <= rampCnt_d;
      duty_q    <= duty_d;
      cmp_q     <= cmp_d;
      deadCnt_q <= deadCnt_d;
      for (int w = 0; w < 2; w++) begin
        state_q[w] <= state_d[w];
        dir_q[w]   <= dir_d[w];
      end
    end
  end

  // ERROR gates the bridge immediately, ahead of the registered clear.
  always_comb begin
    pwm     = '0;
    settled = 1'b1;
    for (int w = 0; w < 2; w++) begin
      pwm[w] = !errorMode && (pwmCnt_q < cmp_q[w]);
      if (state_q[w] != ST_RUN || duty_q[w] != tgtDuty[w] || dir_q[w] != tgtDir[w])
        settled = 1'b0;
    end
  end

  assign l_IN = (errorMode || state_q[1] == ST_DEAD) ? 2'b00 : dir_q[1];
  assign r_IN = (errorMode || state_q[0] == ST_DEAD) ? 2'b00 : dir_q[0];

endmodule

// File: doc/motor_drive.md
MOTOR_DRIVE -- requirements
Module: motor_drive

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PWM_BITS, 10: PWM counter and duty width; period = 2^PWM_BITS clk cycles.
- DUTY_FAST, 700: target duty in STRAIGHT/CHOOSE.
- DUTY_TURN, 600: target duty in LEFT/RIGHT.
- DUTY_SLOW, 450: target duty in BACK/BACK_LEFT.
- RAMP_DIV, 50000: clk cycles between ramp steps.
- RAMP_STEP, 32: duty increment/decrement per ramp step.
- DEAD_CYCLES, 100000: coast time (IN=00) before a direction reversal.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- mode, in, 5: navigation FSM state code.
- pwm, out, 2: {left_pwm, right_pwm} enable PWM.
- l_IN, out, 2: left H-bridge {IN1, IN2}.
- r_IN, out, 2: right H-bridge {IN3, IN4}.
- settled, out, 1: both wheels at target duty and target direction.

REQ-003 There SHALL be one clock; rst is synchronous and active-high, sampled only on posedge clk.

Function
REQ-004 mode decode SHALL give a per-wheel target (direction, duty):
- 3 STRAIGHT, 4 CHOOSE: L FWD/FAST, R FWD/FAST.
- 5 LEFT: L REV/TURN, R FWD/TURN.
- 6 RIGHT: L FWD/TURN, R REV/TURN.
- 7 BACK: L REV/SLOW, R REV/SLOW.
- 8 BACK_LEFT: L OFF/0, R REV/SLOW.
- All other codes (0 IDLE, 1 START, 2 COUNT, 30 STOP, 31 ERROR, undefined): both OFF/0.
REQ-005 Direction encoding on l_IN/r_IN SHALL be FWD=2'b10, REV=2'b01, OFF/coast=2'b00; 2'b11 SHALL never be driven.
REQ-006 A free-running PWM_BITS-bit counter SHALL wrap from 2^PWM_BITS-1 to 0; pwm[w]=1 iff counter < duty_cur[w], so duty 0 gives constant low.
REQ-007 duty_cur SHALL be loaded into the comparator only when the counter wraps to 0, so no PWM period is truncated or glitched.
REQ-008 Each wheel SHALL run an independent FSM with states RUN, DECEL, DEAD:
- RUN: drive dir_cur. Ramp duty_cur toward the target by RAMP_STEP every RAMP_DIV cycles, saturating exactly at the target with no overshoot.
- RUN -> DECEL when the target direction is opposite dir_cur (FWD<->REV).
- DECEL: keep driving dir_cur and ramp duty_cur down toward 0. At duty_cur==0 -> DEAD.
- DEAD: drive IN=00 and duty 0 for DEAD_CYCLES cycles, then load dir_cur = target direction -> RUN.
REQ-009 A target of OFF SHALL NOT need DEAD: the wheel ramps down in RUN, and IN goes to 00 when duty_cur reaches 0. A transition OFF->FWD/REV SHALL load the new direction immediately and ramp up from 0.
REQ-010 If the target direction returns to dir_cur during DECEL, the wheel SHALL go back to RUN and ramp up from the present duty. If it changes during DEAD, the count SHALL complete and the latest target SHALL be used.
REQ-011 The ramp timer SHALL be one shared counter, 0..RAMP_DIV-1, with a tick on wrap. A change of mode SHALL NOT reset it.
REQ-012 mode 31 (ERROR) SHALL bypass ramping: the same cycle forces duty_cur=0 and IN=00 on both wheels, and both FSMs go to RUN with dir_cur=OFF.
REQ-013 settled SHALL be 1 when both wheels are in RUN with duty_cur==target duty and dir_cur==target direction. It is combinational from registered state.
REQ-014 Arithmetic: ramp SHALL be computed in PWM_BITS+1 bits and clamped at 0 and at the target. Targets above 2^PWM_BITS-1 SHALL clamp to 2^PWM_BITS-1.

Reset
REQ-015 While rst=1, the following SHALL be cleared on the next posedge:
- PWM counter, ramp timer, and dead counter = 0.
- duty_cur and comparator duty = 0.
- dir_cur = OFF and FSMs = RUN.
- pwm=00, l_IN=00, r_IN=00, settled=1 (mode decodes OFF).
REQ-016 A reset asserted mid-ramp or mid-DEAD SHALL abort it at once. After release, ramping restarts from 0.

Verification
REQ-017 The bench SHALL use PWM_BITS=4, RAMP_DIV=4, RAMP_STEP=4, DUTY_FAST=12, DUTY_TURN=8, DUTY_SLOW=6, DEAD_CYCLES=8, and cover these scenarios:
- Reset then mode=0 for 100 cycles -> pwm=00, l_IN=r_IN=00, settled=1 throughout.
- mode 0->3 -> l_IN=r_IN=10 at once. duty_cur goes 4,8,12 on successive ramp ticks. settled rises after the third tick. Steady pwm is high 12 of every 16 cycles.
- Settled in mode 3, then mode=7 -> duty ramps 12->8->4->0 with IN=10. Then IN=00 for exactly 8 cycles, then IN=01 and ramp to 6 (4, then 6, clamped).
- Settled in mode 5, then mode=31 -> the next cycle gives pwm=00, l_IN=r_IN=00, settled=1.
- During DECEL (mode 3->7), return to mode 3 before duty reaches 0 -> no DEAD phase; IN stays 10 and duty ramps back to 12.
- rst pulse during DEAD -> all outputs 0 on the next cycle. After release with mode=7, the REV ramp starts from 0 with no further dead time.
